// File: rtl/stack_calc_ctrl.sv
// rtl/stack_calc_ctrl.sv - RPN token controller driving an external stack via push/pop strobes.
// Optional STACK_CALC_MUL_EN enables opcode 3 (MUL); otherwise opcode 3 is rejected as illegal.
module stack_calc_ctrl #(
  parameter int N          = 16,
  parameter int STACK_SIZE = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [2:0]                        in_op,
  input  logic [N-1:0]                      in_data,
  output logic                              res_valid,
  output logic [N-1:0]                      res_data,
  output logic                              err,
  output logic [1:0]                        err_code,
  output logic [$clog2(STACK_SIZE+1)-1:0]   depth,
  output logic                              stk_push,
  output logic                              stk_pop,
  output logic [N-1:0]                      stk_push_data,
  input  logic [N-1:0]                      stk_top,
  input  logic                              stk_empty,
  input  logic                              stk_full
);

  localparam int DW = $clog2(STACK_SIZE + 1);
  localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_SIZE);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_DUP  = 3'd6;
  localparam logic [2:0] OP_DROP = 3'd7;

  typedef enum logic [2:0] {IDLE, POP_B, POP_A, PUSH_R, ERR} state_t;

  state_t       state;
  logic [2:0]   op_q;
  logic [N-1:0] b_q;

  logic is_binary, illegal, underflow, overflow;

  // A is the deeper operand, so SUB yields A - B.
  function automatic logic [N-1:0] alu(input logic [2:0] op, input logic [N-1:0] a,
                                       input logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
`ifdef STACK_CALC_MUL_EN
      OP_MUL:  r = a * b;
`endif
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    is_binary = (in_op >= OP_ADD) && (in_op <= OP_OR);
`ifdef STACK_CALC_MUL_EN
    illegal   = 1'b0;
`else
    illegal   = (in_op == OP_MUL);
`endif
    if (is_binary)
      underflow = (depth < DW'(2));
    else
      underflow = ((in_op == OP_DUP) || (in_op == OP_DROP)) && ((depth == '0) || stk_empty);
    overflow = ((in_op == OP_PUSH) || (in_op == OP_DUP)) && ((depth == FULL_DEPTH) || stk_full);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      res_valid     <= 1'b0;
      res_data      <= '0;
      err           <= 1'b0;
      err_code      <= 2'd0;
      depth         <= '0;
      stk_push      <= 1'b0;
      stk_pop       <= 1'b0;
      stk_push_data <= '0;
      op_q          <= 3'd0;
      b_q           <= '0;
    end else begin
      res_valid <= 1'b0;
      err       <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;

      // Occupancy follows the strobes the stack samples on this same edge.
      if (stk_push)
        depth <= depth + DW'(1);
      else if (stk_pop)
        depth <= depth - DW'(1);

      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= in_op;
            in_ready <= 1'b0;
            if (illegal || underflow || overflow) begin
              state    <= ERR;
              err      <= 1'b1;
              err_code <= illegal ? 2'd3 : (underflow ? 2'd1 : 2'd2);
            end else begin
              case (in_op)
                OP_PUSH: begin
                  stk_push      <= 1'b1;
                  stk_push_data <= in_data;
                  state         <= PUSH_R;
                end
                OP_DUP: begin
                  stk_push      <= 1'b1;
                  stk_push_data <= stk_top;
                  state         <= PUSH_R;
                end
                OP_DROP: begin
                  stk_pop <= 1'b1;
                  state   <= POP_A;
                end
                default: begin
                  stk_pop <= 1'b1;
                  state   <= POP_B;
                end
              endcase
            end
          end
        end
        POP_B: begin
          b_q     <= stk_top;
          stk_pop <= 1'b1;
          state   <= POP_A;
        end
        POP_A: begin
          if (op_q == OP_DROP) begin
            res_data  <= stk_top;
            res_valid <= 1'b1;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            stk_push      <= 1'b1;
            stk_push_data <= alu(op_q, stk_top, b_q);
            state         <= PUSH_R;
          end
        end
        PUSH_R: begin
          res_data  <= stk_push_data;
          res_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_calc_ctrl.sv
// tb/tb_stack_calc_ctrl.sv - directed bench for stack_calc_ctrl with a behavioural stack model.
module tb_stack_calc_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_data;
  logic        res_valid;
  logic [15:0] res_data;
  logic        err;
  logic [1:0]  err_code;
  logic [4:0]  depth;
  logic        stk_push;
  logic        stk_pop;
  logic [15:0] stk_push_data;
  logic [15:0] stk_top;
  logic        stk_empty;
  logic        stk_full;

  int n_assert = 0;
  int n_fail   = 0;

  stack_calc_ctrl #(.N(16), .STACK_SIZE(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .res_valid(res_valid), .res_data(res_data),
    .err(err), .err_code(err_code), .depth(depth), .stk_push(stk_push),
    .stk_pop(stk_pop), .stk_push_data(stk_push_data), .stk_top(stk_top),
    .stk_empty(stk_empty), .stk_full(stk_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [16];
  int sp;
  int push_cnt = 0;
  int pop_cnt  = 0;
  bit both_seen = 0;

  assign stk_top   = (sp > 0) ? mem[sp-1] : 16'd0;
  assign stk_empty = (sp == 0);
  assign stk_full  = (sp == 16);

  always @(posedge clk) begin
    if (!reset) begin
      sp <= 0;
    end else begin
      if (stk_push) push_cnt <= push_cnt + 1;
      if (stk_pop)  pop_cnt  <= pop_cnt + 1;
      if (stk_push && stk_pop) both_seen <= 1;
      if (stk_push && sp < 16) begin
        mem[sp] <= stk_push_data;
        sp <= sp + 1;
      end else if (stk_pop && sp > 0) begin
        sp <= sp - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts cycles after the accept edge until res_valid or err; 0 means timeout.
  task automatic token(input string tag, input logic [2:0] op, input logic [15:0] d,
                       input int exp_lat, input bit exp_err, input logic [31:0] exp_val);
    int  lat;
    bit  done;
    bit  got_err;
    lat = 0; done = 0; got_err = 0;
    send(op, d);
    for (int i = 1; i <= 10 && !done; i++) begin
      @(negedge clk);
      if (res_valid || err) begin
        done = 1; lat = i; got_err = err;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, got_err, exp_err);
    if (exp_err) check({tag, "_code"}, err_code, exp_val);
    else         check({tag, "_res"}, res_data, exp_val);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  int pc, qc;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_data = 16'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_depth", depth, 0);
    check("rst_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_strobes", {stk_push, stk_pop}, 0);
    check("rst_push_data", stk_push_data, 0);

    token("push10", 3'd0, 16'd10, 2, 0, 10);
    token("push20", 3'd0, 16'd20, 2, 0, 20);
    check("depth2", depth, 2);
    check("top20", stk_top, 20);

    pc = push_cnt; qc = pop_cnt;
    token("sub", 3'd2, 16'd0, 4, 0, 65526);
    check("sub_depth", depth, 1);
    check("sub_pops", pop_cnt - qc, 2);
    check("sub_pushes", push_cnt - pc, 1);
    check("sub_top", stk_top, 65526);

    token("drop", 3'd7, 16'd0, 2, 0, 65526);
    check("drop_depth", depth, 0);

    pc = push_cnt; qc = pop_cnt;
    token("add_empty", 3'd1, 16'd0, 1, 1, 1);
    @(negedge clk);
    check("err_pulse_end", err, 0);
    token("dup_empty", 3'd6, 16'd0, 1, 1, 1);
    token("drop_empty", 3'd7, 16'd0, 1, 1, 1);
    check("underflow_no_strobes", (push_cnt - pc) + (pop_cnt - qc), 0);
    check("underflow_depth", depth, 0);
    check("res_data_held", res_data, 65526);

    for (int i = 1; i <= 16; i++) token("fill", 3'd0, 16'(i), 2, 0, i);
    check("full_depth", depth, 16);
    check("full_flag", stk_full, 1);
    pc = push_cnt; qc = pop_cnt;
    token("push_over", 3'd0, 16'd99, 1, 1, 2);
    token("dup_over", 3'd6, 16'd0, 1, 1, 2);
    check("over_depth", depth, 16);
    check("over_no_strobes", (push_cnt - pc) + (pop_cnt - qc), 0);
    check("over_top", stk_top, 16);

    do_reset();
    @(negedge clk);
    check("rst2_depth", depth, 0);
    token("push300", 3'd0, 16'd300, 2, 0, 300);
    token("dup300", 3'd6, 16'd0, 2, 0, 300);
    check("dup_depth", depth, 2);
    pc = push_cnt; qc = pop_cnt;
`ifdef STACK_CALC_MUL_EN
    token("mul", 3'd3, 16'd0, 4, 0, 24464);
    check("mul_depth", depth, 1);
    check("mul_top", stk_top, 24464);
`else
    token("mul_illegal", 3'd3, 16'd0, 1, 1, 3);
    check("mul_depth", depth, 2);
    check("mul_no_strobes", (push_cnt - pc) + (pop_cnt - qc), 0);
    check("mul_top", stk_top, 300);
`endif

    do_reset();
    token("p_0f0f", 3'd0, 16'h0F0F, 2, 0, 16'h0F0F);
    token("p_00ff", 3'd0, 16'h00FF, 2, 0, 16'h00FF);
    token("and", 3'd4, 16'd0, 4, 0, 16'h000F);
    token("p_f000", 3'd0, 16'hF000, 2, 0, 16'hF000);
    token("or", 3'd5, 16'd0, 4, 0, 16'hF00F);
    token("p_7", 3'd0, 16'd7, 2, 0, 7);
    token("add", 3'd1, 16'd0, 4, 0, 16'hF016);
    check("alu_depth", depth, 1);

    do_reset();
    token("p1", 3'd0, 16'd1, 2, 0, 1);
    token("p2", 3'd0, 16'd2, 2, 0, 2);
    send(3'd1, 16'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    pc = push_cnt;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_depth", depth, 0);
    check("abort_ready", in_ready, 1);
    check("abort_push", stk_push, 0);
    repeat (3) @(negedge clk);
    check("abort_no_push", push_cnt - pc, 0);
    token("p5", 3'd0, 16'd5, 2, 0, 5);
    check("p5_depth", depth, 1);

    check("never_both_strobes", both_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
